triangle_fetch: RTL and testbench

//  Sits between the on-chip triangle list and the rasterizer.
//  On frame_start it walks the list once, with the list read latency handled internally.

---
 rtl/triangle_fetch.sv | 144 ++++++++++++++
 tb/tb_triangle_fetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_fetch.sv
// Walks the on-chip triangle list once per frame and hands each triangle to the
// rasterizer through a held valid/ready register, absorbing the list read latency.
module triangle_fetch #(
    parameter int WI      = 8,
    parameter int WF      = 8,
    parameter int Waddr   = 7,
    parameter int RD_LAT  = 1,
    parameter int MAX_TRI = 100
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          frame_start,
    input  logic                          frame_abort,
    input  logic                          list_empty,
    input  logic                          list_read_done,
    input  logic [2:0][2:0][WI+WF-1:0]    list_triangle,
    output logic                          list_r_en,
    output logic [2:0][2:0][WI+WF-1:0]    tri_out,
    output logic                          tri_valid,
    input  logic                          tri_ready,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [Waddr-1:0]              tri_count
);

    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_CAPT = 3'd2,
        S_HOLD = 3'd3,
        S_ADV  = 3'd4,
        S_CHK  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [LW-1:0]                r_lat_cnt;
    logic [2:0][2:0][WI+WF-1:0]   r_tri_out;
    logic                         r_tri_valid;
    logic                         r_list_r_en;
    logic                         r_busy;
    logic                         r_frame_done;
    logic                         r_overflow;
    logic [Waddr-1:0]             r_tri_count;
    logic                         w_accept;
    logic                         w_last;
    logic                         w_start;

    assign w_accept = (r_state == S_HOLD) & r_tri_valid & tri_ready;
    assign w_last   = (r_tri_count == Waddr'(MAX_TRI - 1));
    assign w_start  = (r_state == S_IDLE) & frame_start & ~frame_abort;

    // Next-state logic; abort overrides every state
    always_comb begin
        w_next = r_state;
        if (frame_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_start) w_next = list_empty ? S_DONE : S_WAIT;
                    else             w_next = S_IDLE;
                end
                S_WAIT: begin
                    if (r_lat_cnt == LW'(0)) w_next = S_CAPT;
                    else                     w_next = S_WAIT;
                end
                S_CAPT: w_next = S_HOLD;
                S_HOLD: begin
                    if (w_accept) w_next = w_last ? S_DONE : S_ADV;
                    else          w_next = S_HOLD;
                end
                S_ADV:  w_next = S_CHK;
                S_CHK: begin
                    if (list_read_done) w_next = S_DONE;
                    else                w_next = S_WAIT;
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // State, registered outputs (decoded from next state so they align with it) and counters
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_lat_cnt    <= LW'(0);
            r_tri_out    <= '0;
            r_tri_valid  <= 1'b0;
            r_list_r_en  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_tri_count  <= Waddr'(0);
        end else begin
            r_state      <= w_next;
            r_tri_valid  <= (w_next == S_HOLD);
            r_list_r_en  <= (w_next == S_ADV);
            r_busy       <= (w_next == S_WAIT) || (w_next == S_CAPT) || (w_next == S_HOLD) ||
                            (w_next == S_ADV)  || (w_next == S_CHK);
            r_frame_done <= (w_next == S_DONE);

            if ((w_next == S_WAIT) && (r_state != S_WAIT)) begin
                r_lat_cnt <= LW'(RD_LAT - 1);
            end else if ((r_state == S_WAIT) && (r_lat_cnt != LW'(0))) begin
                r_lat_cnt <= r_lat_cnt - LW'(1);
            end else begin
                r_lat_cnt <= r_lat_cnt;
            end

            if ((r_state == S_CAPT) && !frame_abort) begin
                r_tri_out <= list_triangle;
            end else begin
                r_tri_out <= r_tri_out;
            end

            // Count is cleared only by an accepted start and survives abort and done
            if (w_start) begin
                r_tri_count <= Waddr'(0);
                r_overflow  <= 1'b0;
            end else if (w_accept && !frame_abort) begin
                r_tri_count <= r_tri_count + Waddr'(1);
                r_overflow  <= r_overflow | w_last;
            end else begin
                r_tri_count <= r_tri_count;
                r_overflow  <= r_overflow;
            end
        end
    end

    assign list_r_en  = r_list_r_en;
    assign tri_out    = r_tri_out;
    assign tri_valid  = r_tri_valid;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign tri_count  = r_tri_count;

endmodule

// File: tb/tb_triangle_fetch.sv
// Directed bench for triangle_fetch: table-driven frame walks plus hand-written
// latency, backpressure, abort and reset sequences against a behavioural list.
module tb_triangle_fetch;

    typedef logic [2:0][2:0][15:0] tri_t;

    typedef struct {
        string name;
        int    n_entries;
        int    exp_cnt;
        int    exp_ren;
        bit    exp_ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       fs_a, fs_b, abort, rdy, lrst;
    int         n_a, n_b;
    int         ptr_a, ptr_b;
    logic       rdd_a, rdd_b;
    tri_t       lt_a, lt_b, to_a, to_b;
    logic       ren_a, ren_b, tv_a, tv_b, busy_a, busy_b, fd_a, fd_b, ovf_a, ovf_b;
    logic [6:0] cnt_a, cnt_b;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    function automatic tri_t tri_val(input int k);
        tri_t t;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                t[i][j] = 16'((k + 1) * 256 + i * 16 + j * 2 + 1);
        return t;
    endfunction

    // Behavioural lists: pointer advances on r_en, read_done pulses after passing the last entry
    always @(posedge clk) begin
        if (lrst) begin
            ptr_a <= 0; rdd_a <= 1'b0; ptr_b <= 0; rdd_b <= 1'b0;
        end else begin
            rdd_a <= ren_a && (ptr_a == n_a - 1);
            rdd_b <= ren_b && (ptr_b == n_b - 1);
            if (ren_a) ptr_a <= ptr_a + 1;
            if (ren_b) ptr_b <= ptr_b + 1;
        end
    end

    always_comb begin
        lt_a = tri_val(ptr_a);
        lt_b = tri_val(ptr_b);
    end

    triangle_fetch #(.WI(8), .WF(8), .Waddr(7), .RD_LAT(1), .MAX_TRI(4)) u_dut_a (
        .Clk(clk), .Reset(rst), .frame_start(fs_a), .frame_abort(abort),
        .list_empty(n_a == 0), .list_read_done(rdd_a), .list_triangle(lt_a),
        .list_r_en(ren_a), .tri_out(to_a), .tri_valid(tv_a), .tri_ready(rdy),
        .busy(busy_a), .frame_done(fd_a), .overflow(ovf_a), .tri_count(cnt_a)
    );

    triangle_fetch #(.WI(8), .WF(8), .Waddr(7), .RD_LAT(3), .MAX_TRI(100)) u_dut_b (
        .Clk(clk), .Reset(rst), .frame_start(fs_b), .frame_abort(abort),
        .list_empty(n_b == 0), .list_read_done(rdd_b), .list_triangle(lt_b),
        .list_r_en(ren_b), .tri_out(to_b), .tri_valid(tv_b), .tri_ready(rdy),
        .busy(busy_b), .frame_done(fd_b), .overflow(ovf_b), .tri_count(cnt_b)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic list_reset();
        lrst = 1'b1;
        tick();
        lrst = 1'b0;
    endtask

    // Ticks until tri_valid of the selected instance rises; returns the number of ticks taken
    task automatic wait_tv(input bit sel, output int lat);
        lat = 0;
        while (!(sel ? tv_b : tv_a) && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_frame(input vec_t v);
        int beats, rens;
        bit done;
        n_a = v.n_entries;
        list_reset();
        rdy  = 1'b1;
        fs_a = 1'b1;
        tick();
        fs_a  = 1'b0;
        beats = 0;
        rens  = 0;
        done  = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (tv_a) begin
                chk({v.name, "_tri_out"}, to_a, tri_val(beats));
                beats++;
            end
            if (ren_a) rens++;
            if (fd_a) done = 1'b1;
            else      tick();
        end
        chk({v.name, "_done_seen"}, done, 1'b1);
        chk({v.name, "_beats"}, beats, v.exp_cnt);
        chk({v.name, "_r_en_pulses"}, rens, v.exp_ren);
        chk({v.name, "_tri_count"}, cnt_a, v.exp_cnt);
        chk({v.name, "_overflow"}, ovf_a, v.exp_ovf);
        chk({v.name, "_busy_in_done"}, busy_a, 1'b0);
        tick();
        chk({v.name, "_done_one_cycle"}, fd_a, 1'b0);
        chk({v.name, "_count_held"}, cnt_a, v.exp_cnt);
        rdy = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        int   lat;
        bit   seen_fd;
        tri_t held;

        vecs[0] = '{"three", 3, 3, 3, 1'b0};
        vecs[1] = '{"empty", 0, 0, 0, 1'b0};
        vecs[2] = '{"one", 1, 1, 1, 1'b0};
        vecs[3] = '{"wdog_nodone", 10, 4, 3, 1'b1};
        vecs[4] = '{"wdog_exact", 4, 4, 3, 1'b1};

        rst = 1'b1; fs_a = 1'b0; fs_b = 1'b0; abort = 1'b0; rdy = 1'b0; lrst = 1'b1;
        n_a = 3; n_b = 2;
        tick();
        tick();
        chk("rst_tri_valid", tv_a, 1'b0);
        chk("rst_list_r_en", ren_a, 1'b0);
        chk("rst_tri_out", to_a, 144'd0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_frame_done", fd_a, 1'b0);
        chk("rst_overflow", ovf_a, 1'b0);
        chk("rst_tri_count", cnt_a, 7'd0);
        rst  = 1'b0;
        lrst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Latency, backpressure, ignored start, then abort in HOLD of the 2nd triangle
        n_a = 3;
        list_reset();
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        chk("start_clears_overflow", ovf_a, 1'b0);
        chk("start_clears_count", cnt_a, 7'd0);
        chk("busy_after_start", busy_a, 1'b1);
        wait_tv(1'b0, lat);
        chk("lat_first_rd1", lat, 2);
        held = to_a;
        chk("bp_first_tri", held, tri_val(0));
        for (int c = 0; c < 5; c++) begin
            fs_a = (c == 2);
            tick();
            chk("bp_valid", tv_a, 1'b1);
            chk("bp_stable", to_a, held);
            chk("bp_no_r_en", ren_a, 1'b0);
            chk("bp_count", cnt_a, 7'd0);
        end
        fs_a = 1'b0;
        rdy  = 1'b1;
        tick();
        rdy = 1'b0;
        chk("accept_count", cnt_a, 7'd1);
        chk("accept_valid_drop", tv_a, 1'b0);
        chk("accept_r_en", ren_a, 1'b1);
        wait_tv(1'b0, lat);
        chk("lat_next_rd1", lat, 4);
        chk("second_tri", to_a, tri_val(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", tv_a, 1'b0);
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_count_kept", cnt_a, 7'd1);
        seen_fd = fd_a;
        for (int c = 0; c < 4; c++) begin
            tick();
            seen_fd = seen_fd | fd_a;
        end
        chk("abort_no_done", seen_fd, 1'b0);

        // Abort wins over a simultaneous start
        fs_a  = 1'b1;
        abort = 1'b1;
        tick();
        fs_a  = 1'b0;
        abort = 1'b0;
        chk("abort_wins_busy", busy_a, 1'b0);
        chk("abort_wins_count", cnt_a, 7'd1);

        // RD_LAT=3 instance, two entries
        n_b = 2;
        list_reset();
        fs_b = 1'b1;
        tick();
        fs_b = 1'b0;
        wait_tv(1'b1, lat);
        chk("lat_first_rd3", lat, 4);
        chk("rd3_tri0", to_b, tri_val(0));
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        wait_tv(1'b1, lat);
        chk("lat_next_rd3", lat, 6);
        chk("rd3_tri1", to_b, tri_val(1));
        rdy = 1'b1;
        lat = 0;
        while (!fd_b && lat < 20) begin
            tick();
            lat++;
        end
        rdy = 1'b0;
        chk("rd3_done", fd_b, 1'b1);
        chk("rd3_count", cnt_b, 7'd2);
        chk("rd3_overflow", ovf_b, 1'b0);

        // Asynchronous reset while holding the 2nd triangle
        n_a = 3;
        list_reset();
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        wait_tv(1'b0, lat);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        wait_tv(1'b0, lat);
        chk("pre_reset_hold", tv_a, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_tri_valid", tv_a, 1'b0);
        chk("arst_tri_out", to_a, 144'd0);
        chk("arst_busy", busy_a, 1'b0);
        chk("arst_frame_done", fd_a, 1'b0);
        chk("arst_tri_count", cnt_a, 7'd0);
        chk("arst_list_r_en", ren_a, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        run_frame(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
